// File: rtl/isqrt_iterative_responder_pkg.sv
// Shared types and widths for the iterative integer square-root responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package isqrt_resp_pkg;

    localparam int X_W    = 32;
    localparam int REM_W  = 18;
    localparam int ROOT_W = 16;
    localparam int CNT_W  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    // Number of core iterations needed to resolve all 16 result bits.
    function automatic int iterations(input int bpc);
        return 16 / bpc;
    endfunction

endpackage

// File: rtl/isqrt_iterative_responder_if.sv
// Request/response bundle between an isqrt initiator and the responder.
// Latency: none (wiring only).
// Backpressure: none; the responder buffers one request and flags drops.
interface isqrt_resp_if;
    import isqrt_resp_pkg::*;

    logic              x_vld;
    logic [X_W-1:0]    x;
    logic              y_vld;
    logic [ROOT_W-1:0] y;
    logic              busy;
    logic              overflow;

    modport master (
        output x_vld, x,
        input  y_vld, y, busy, overflow
    );

    modport slave (
        input  x_vld, x,
        output y_vld, y, busy, overflow
    );

endinterface

// File: rtl/isqrt_iterative_responder_iter_step.sv
// One restoring square-root digit step: consumes one operand bit pair.
// Latency: combinational.
// Backpressure: none.
module isqrt_iter_step
    import isqrt_resp_pkg::*;
(
    input  logic [REM_W-1:0]  rem,
    input  logic [ROOT_W-1:0] root,
    input  logic [1:0]        pair,
    output logic [REM_W-1:0]  rem_nxt,
    output logic [ROOT_W-1:0] root_nxt
);

    logic [REM_W-1:0] shifted;
    logic [REM_W-1:0] subtrahend;
    logic [REM_W:0]   trial;

    // Trial subtraction; the extra MSB of trial is the borrow (negative result).
    // The partial root never exceeds 15 bits before the last step, so the
    // shifted values fit the 18-bit remainder without loss.
    always_comb begin
        shifted    = {rem[REM_W-3:0], pair};
        subtrahend = {root, 2'b01};
        trial      = {1'b0, shifted} - {1'b0, subtrahend};
        if (!trial[REM_W]) begin
            rem_nxt  = trial[REM_W-1:0];
            root_nxt = {root[ROOT_W-2:0], 1'b1};
        end else begin
            rem_nxt  = shifted;
            root_nxt = {root[ROOT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/isqrt_iterative_responder.sv
// floor(sqrt(x)) responder: iterative restoring core plus a one-entry pending buffer.
// Latency: 16/BITS_PER_CYCLE + 1 cycles from request to the y_vld pulse.
// Backpressure: none; a request arriving while core and pending are both full is dropped and sets sticky overflow.
module isqrt_iterative_responder
    import isqrt_resp_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    isqrt_resp_if.slave  bus
);

    localparam int               N    = iterations(BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
          BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must be one of 1, 2, 4, 8, 16");
    end

    state_t            state;
    state_t            state_nxt;
    logic [X_W-1:0]    opnd;
    logic [X_W-1:0]    pend;
    logic              pend_vld;
    logic [REM_W-1:0]  rem;
    logic [ROOT_W-1:0] root;
    logic [CNT_W-1:0]  cnt;
    logic              done;
    logic              load;
    logic [X_W-1:0]    load_opnd;
    logic              y_vld_q;
    logic [ROOT_W-1:0] y_q;
    logic              ovf_q;
    logic              busy_c;
    logic [REM_W-1:0]  rem_fin;
    logic [ROOT_W-1:0] root_fin;

    // Chain of BITS_PER_CYCLE digit steps, MSB pair of the operand first.
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        logic [REM_W-1:0]  rem_i;
        logic [REM_W-1:0]  rem_o;
        logic [ROOT_W-1:0] root_i;
        logic [ROOT_W-1:0] root_o;
        if (i == 0) begin : g_first
            assign rem_i  = rem;
            assign root_i = root;
        end else begin : g_next
            assign rem_i  = g_step[i-1].rem_o;
            assign root_i = g_step[i-1].root_o;
        end
        isqrt_iter_step u_step (
            .rem      (rem_i),
            .root     (root_i),
            .pair     (opnd[X_W-1-2*i -: 2]),
            .rem_nxt  (rem_o),
            .root_nxt (root_o)
        );
    end

    assign rem_fin  = g_step[BITS_PER_CYCLE-1].rem_o;
    assign root_fin = g_step[BITS_PER_CYCLE-1].root_o;

    // Control decode: completion edge and where the next core operand comes from.
    always_comb begin
        done      = (state == ST_CALC) && (cnt == LAST);
        load      = ((state == ST_IDLE) && bus.x_vld) || (done && (pend_vld || bus.x_vld));
        load_opnd = (done && pend_vld) ? pend : bus.x;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: stay in CALC across a completion when another operand is ready.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.x_vld) state_nxt = ST_CALC;
            ST_CALC: if (done && !pend_vld && !bus.x_vld) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy_c = (state == ST_CALC);
    end

    // Core datapath: load a fresh operand or advance one iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
        end else if (load) begin
            opnd <= load_opnd;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
        end else if (state == ST_CALC) begin
            opnd <= opnd << (2 * BITS_PER_CYCLE);
            rem  <= rem_fin;
            root <= root_fin;
            cnt  <= done ? '0 : cnt + CNT_W'(1);
        end
    end

    // Pending buffer and sticky drop flag. At completion the pending entry moves
    // into the core, so the slot is free again for a same-cycle request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend     <= '0;
            ovf_q    <= 1'b0;
        end else if (done) begin
            if (pend_vld) begin
                pend_vld <= bus.x_vld;
                if (bus.x_vld) pend <= bus.x;
            end
        end else if ((state == ST_CALC) && bus.x_vld) begin
            if (!pend_vld) begin
                pend_vld <= 1'b1;
                pend     <= bus.x;
            end else begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Result register: single-cycle strobe, value held until the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_vld_q <= 1'b0;
            y_q     <= '0;
        end else begin
            y_vld_q <= done;
            if (done) y_q <= root_fin;
        end
    end

    assign bus.y_vld    = y_vld_q;
    assign bus.y        = y_q;
    assign bus.busy     = busy_c;
    assign bus.overflow = ovf_q;

    logic unused_rem_msbs;
    assign unused_rem_msbs = ^rem[REM_W-1:REM_W-2];

endmodule
